// File: rtl/instruction_sequencer_pkg.sv
// Shared constants and types for the program-memory instruction sequencer.
// Word sentinels, opcodes and the sequencer state encoding live here.
package instruction_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        WAIT_TENSOR,
        HALTED
    } sequencer_state_t;

    localparam logic [15:0] DEFAULT_HALT_WORD      = 16'hFFFF;
    localparam logic [15:0] DEFAULT_NOP_WORD       = 16'h9000;
    localparam logic [3:0]  NOP_OPCODE             = 4'b1001;
    localparam logic [3:0]  DEFAULT_OPERATE_OPCODE = 4'b0101;

    // Minimum number of cycles spent waiting on the tensor core.
    localparam int TENSOR_MIN_WAIT = 2;

endpackage

// File: rtl/instruction_sequencer_tensor_wait_timer.sv
// Qualifies tensor_core_done_in with a minimum wait so a stale done flag
// left over from a previous operation cannot end the wait early.
module tensor_wait_timer
    import instruction_sequencer_pkg::*;
#(
    parameter int MIN_WAIT = TENSOR_MIN_WAIT
) (
    input  logic clock_in,
    input  logic reset_n_in,
    input  logic waiting,
    input  logic tensor_core_done_in,
    output logic wait_over
);

    localparam int EW = $clog2(MIN_WAIT + 1);
    localparam logic [EW-1:0] MIN_ELAPSED = EW'(MIN_WAIT - 1);

    // Edges already spent waiting, saturating once the minimum is reached.
    logic [EW-1:0] elapsed;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            elapsed <= '0;
        end else if (!waiting) begin
            elapsed <= '0;
        end else if (elapsed != MIN_ELAPSED) begin
            elapsed <= elapsed + 1'b1;
        end
    end

    assign wait_over = waiting && (elapsed == MIN_ELAPSED) && tensor_core_done_in;

endmodule

// File: rtl/instruction_sequencer.sv
// Fetches words from a registered-read program memory and issues them to the
// cpu one per cycle, stalling on tensor-core operates and stopping on HALT_WORD.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int                           ADDRESS_WIDTH     = 10,
    parameter int                           INSTRUCTION_WIDTH = 16,
    parameter logic [INSTRUCTION_WIDTH-1:0] HALT_WORD         = DEFAULT_HALT_WORD,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_WORD          = DEFAULT_NOP_WORD,
    parameter logic [3:0]                   OPERATE_OPCODE    = DEFAULT_OPERATE_OPCODE
) (
    input  logic                         clock_in,
    input  logic                         reset_n_in,
    input  logic                         start_in,
    input  logic [ADDRESS_WIDTH-1:0]     start_address_in,
    output logic [ADDRESS_WIDTH-1:0]     memory_address_out,
    output logic                         memory_read_enable_out,
    input  logic [INSTRUCTION_WIDTH-1:0] memory_data_in,
    input  logic                         tensor_core_done_in,
    output logic [INSTRUCTION_WIDTH-1:0] current_instruction_out,
    output logic                         instruction_valid_out,
    output logic                         busy_out,
    output logic                         done_out,
    output logic                         error_out,
    output logic [ADDRESS_WIDTH:0]       instruction_count_out
);

    // pc carries one extra bit so stepping past the top address is visible
    // rather than silently wrapping to zero.
    localparam logic [ADDRESS_WIDTH:0] PC_PAST_END = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    sequencer_state_t       state;
    logic [ADDRESS_WIDTH:0] pc;
    logic                   data_is_halt;
    logic                   data_is_operate;
    logic                   data_is_last;
    logic                   wait_over;

    assign memory_address_out = pc[ADDRESS_WIDTH-1:0];
    assign data_is_halt       = (memory_data_in == HALT_WORD);
    assign data_is_operate    = (memory_data_in[INSTRUCTION_WIDTH-1 -: 4] == OPERATE_OPCODE);
    // In RUN the data in hand belongs to pc-1, so this flags the top address.
    assign data_is_last       = (pc == PC_PAST_END);

    tensor_wait_timer #(
        .MIN_WAIT (TENSOR_MIN_WAIT)
    ) u_tensor_wait_timer (
        .clock_in            (clock_in),
        .reset_n_in          (reset_n_in),
        .waiting             (state == WAIT_TENSOR),
        .tensor_core_done_in (tensor_core_done_in),
        .wait_over           (wait_over)
    );

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state                   <= IDLE;
            pc                      <= '0;
            current_instruction_out <= NOP_WORD;
            instruction_valid_out   <= 1'b0;
            busy_out                <= 1'b0;
            done_out                <= 1'b0;
            error_out               <= 1'b0;
            instruction_count_out   <= '0;
            memory_read_enable_out  <= 1'b0;
        end else begin
            done_out                <= 1'b0;
            instruction_valid_out   <= 1'b0;
            current_instruction_out <= NOP_WORD;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        pc                     <= {1'b0, start_address_in};
                        instruction_count_out  <= '0;
                        error_out              <= 1'b0;
                        busy_out               <= 1'b1;
                        memory_read_enable_out <= 1'b1;
                        state                  <= PRIME;
                    end
                end
                PRIME: begin
                    pc    <= pc + 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    if (data_is_halt) begin
                        done_out               <= 1'b1;
                        busy_out               <= 1'b0;
                        memory_read_enable_out <= 1'b0;
                        state                  <= HALTED;
                    end else begin
                        current_instruction_out <= memory_data_in;
                        instruction_valid_out   <= 1'b1;
                        instruction_count_out   <= instruction_count_out + 1'b1;
                        if (data_is_last) begin
                            error_out              <= 1'b1;
                            done_out               <= 1'b1;
                            busy_out               <= 1'b0;
                            memory_read_enable_out <= 1'b0;
                            state                  <= HALTED;
                        end else if (data_is_operate) begin
                            // pc stays put so the stall keeps fetching the next word.
                            state <= WAIT_TENSOR;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                WAIT_TENSOR: begin
                    if (wait_over) begin
                        pc    <= pc + 1'b1;
                        state <= RUN;
                    end
                end
                HALTED: begin
                    if (!start_in) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
